// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB per opcode, handshakes with a
// variable-latency memory through mem_ready, watches for memory stalls
// that never end, and counts retired instructions.
// Optional feature: define MC_BNE_EN to decode bne (opcode 000101) as a
// branch with branch_ne=1; without it branch_ne is tied 0 and 000101 is
// an illegal opcode.
module multicycle_control #(
    parameter int TIMEOUT = 15,  // consecutive stall cycles before ERR, >= 1
    parameter int CNT_W   = 32   // width of instr_count
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [4:0]       rt,
    input  logic [4:0]       rd,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             branch_ne,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       mem_size,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal,
    output logic             timeout_err,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC      = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_ERR       = 4'd15
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_size;
        logic       ir_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MC_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    // Wide enough to hold 0..TIMEOUT; the ERR decision fires at TIMEOUT-1.
    localparam int               WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              terr_q, terr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    state_e            dec_next;
    logic              dec_legal;
    logic              retire;
    logic              stalled;
    ctl_t              ctl, ctl_gated;

    // Access width for loads/stores comes from the low opcode bits.
    function automatic logic [1:0] size_of(input logic [1:0] sel);
        case (sel)
            2'b11:   return 2'b00;  // word
            2'b01:   return 2'b01;  // half
            2'b00:   return 2'b10;  // byte
            default: return 2'b00;
        endcase
    endfunction

    // Opcode decode used by DECODE: where to go and whether it is legal.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path can leave it unassigned and infer a latch.
        dec_next  = S_FETCH;
        dec_legal = 1'b1;
        case (opcode)
            OP_LW, OP_LH, OP_LB,
            OP_SW, OP_SH, OP_SB: dec_next = S_MEM_ADDR;
            OP_RTYPE:            dec_next = S_EXEC;
            OP_BEQ:              dec_next = S_BRANCH;
            OP_J:                dec_next = S_JUMP;
            OP_ADDI:             dec_next = S_ADDI_EXEC;
`ifdef MC_BNE_EN
            OP_BNE:              dec_next = S_BRANCH;
`endif
            default:             dec_legal = 1'b0;
        endcase
    end

    // Next-state, stall watchdog and retirement counter logic.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        terr_d  = terr_q;
        cnt_d   = cnt_q;
        retire  = 1'b0;

        case (state_q)
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE:    state_d = dec_next;
            S_MEM_ADDR:  state_d = opcode[3] ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WRITE: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC:      state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_ERR:       state_d = S_ERR;
            default:     state_d = S_FETCH;
        endcase

        // A stall cycle is a wait state without mem_ready; a ready memory on
        // the last allowed cycle takes the normal transition above.
        stalled = ((state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                   (state_q == S_MEM_WRITE)) && !mem_ready;
        if (stalled && (wait_q == WAIT_LAST)) begin
            state_d = S_ERR;
            terr_d  = 1'b1;
        end

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (stalled) begin
            wait_d = wait_q + WAIT_W'(1);
        end

        if (retire) cnt_d = cnt_q + CNT_W'(1);
    end

    // State and bookkeeping registers; reset dominates any increment.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the values from before this clock edge.
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            terr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            terr_q  <= terr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Control word decoded from the current state; unlisted fields stay 0.
    always_comb begin
        ctl = '0;
        case (state_q)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = 2'b01;
                ctl.ir_write  = mem_ready;
                ctl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctl.alu_src_b = 2'b11;
                ctl.illegal   = !dec_legal;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
                ctl.mem_size = size_of(opcode[1:0]);
            end
            S_MEM_WB: begin
                ctl.mem_to_reg = 1'b1;
                ctl.reg_write  = (rt != 5'd0);
            end
            S_MEM_WRITE: begin
                ctl.mem_write = 1'b1;
                ctl.i_or_d    = 1'b1;
                ctl.mem_size  = size_of(opcode[1:0]);
            end
            S_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = 2'b10;
            end
            S_R_WB: begin
                ctl.reg_dst   = 1'b1;
                ctl.reg_write = (rd != 5'd0);
            end
            S_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_op        = 2'b01;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = 2'b01;
`ifdef MC_BNE_EN
                ctl.branch_ne     = (opcode == OP_BNE);
`endif
            end
            S_JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = 2'b10;
            end
            S_ADDI_WB: begin
                ctl.reg_write = (rt != 5'd0);
            end
            default: ;
        endcase
    end

    // Strobes are held low while reset is asserted.
    assign ctl_gated     = rst ? '0 : ctl;

    assign pc_write      = ctl_gated.pc_write;
    assign pc_write_cond = ctl_gated.pc_write_cond;
    assign branch_ne     = ctl_gated.branch_ne;
    assign i_or_d        = ctl_gated.i_or_d;
    assign mem_read      = ctl_gated.mem_read;
    assign mem_write     = ctl_gated.mem_write;
    assign mem_size      = ctl_gated.mem_size;
    assign ir_write      = ctl_gated.ir_write;
    assign reg_write     = ctl_gated.reg_write;
    assign mem_to_reg    = ctl_gated.mem_to_reg;
    assign reg_dst       = ctl_gated.reg_dst;
    assign alu_src_a     = ctl_gated.alu_src_a;
    assign alu_src_b     = ctl_gated.alu_src_b;
    assign alu_op        = ctl_gated.alu_op;
    assign pc_source     = ctl_gated.pc_source;
    assign illegal       = ctl_gated.illegal;

    assign state         = rst ? 4'd0 : state_q;
    assign timeout_err   = terr_q;
    assign instr_count   = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the stimulus process drives one
// cycle of inputs and pushes the expected state/control/counter response;
// a monitor on the falling edge pops and compares it.
module tb_multicycle_control;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
    logic [1:0]  mem_size;
    logic        ir_write, reg_write, mem_to_reg, reg_dst, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic        illegal, timeout_err;
    logic [31:0] instr_count;

`ifdef MC_BNE_EN
    localparam int BNE_INC = 1;
`else
    localparam int BNE_INC = 0;
`endif

    typedef struct {
        string       nm;
        logic [3:0]  st;
        logic [19:0] ctl;
        logic [31:0] cnt;
        logic        terr;
        logic        full;  // counter and flag compared only outside reset
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    multicycle_control #(.TIMEOUT(15), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .rt(rt), .rd(rd),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .branch_ne(branch_ne), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .mem_size(mem_size), .ir_write(ir_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .illegal(illegal),
        .timeout_err(timeout_err), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic legal_op(input logic [5:0] op);
        case (op)
            6'h23, 6'h21, 6'h20, 6'h2B, 6'h29, 6'h28,
            6'h00, 6'h04, 6'h02, 6'h08: return 1'b1;
            6'h05:                      return (BNE_INC == 1);
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] size_tab(input logic [5:0] op);
        case (op[1:0])
            2'b11:   return 2'b00;
            2'b01:   return 2'b01;
            2'b00:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Reference control word per state, in port order:
    // pc_write pc_write_cond branch_ne i_or_d mem_read mem_write mem_size
    // ir_write reg_write mem_to_reg reg_dst alu_src_a alu_src_b alu_op pc_source illegal
    function automatic logic [19:0] model(input logic r, input logic [3:0] st,
                                          input logic [5:0] op, input logic [4:0] t,
                                          input logic [4:0] d, input logic mr);
        logic pcw, pcwc, bne, iord, mrd, mwr, irw, rw, m2r, rdst, asa, ill;
        logic [1:0] sz, asb, aop, psrc;
        {pcw, pcwc, bne, iord, mrd, mwr, irw, rw, m2r, rdst, asa, ill} = '0;
        {sz, asb, aop, psrc} = '0;
        case (st)
            4'd0:  begin mrd = 1; asb = 2'b01; pcw = mr; irw = mr; end
            4'd1:  begin asb = 2'b11; ill = !legal_op(op); end
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mrd = 1; iord = 1; sz = size_tab(op); end
            4'd4:  begin m2r = 1; rw = (t != 0); end
            4'd5:  begin mwr = 1; iord = 1; sz = size_tab(op); end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  begin rdst = 1; rw = (d != 0); end
            4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; bne = (op == 6'h05); end
            4'd9:  begin pcw = 1; psrc = 2'b10; end
            4'd10: begin asa = 1; asb = 2'b10; end
            4'd11: begin rw = (t != 0); end
            default: ;
        endcase
        if (r) return '0;
        return {pcw, pcwc, bne, iord, mrd, mwr, sz, irw, rw, m2r, rdst, asa, asb, aop, psrc, ill};
    endfunction

    // One clock cycle of stimulus plus its expected response.
    task automatic step(input string nm, input logic r, input logic [5:0] op,
                        input logic [4:0] t, input logic [4:0] d, input logic mr,
                        input logic [3:0] st, input int cnt, input logic terr);
        exp_t e;
        rst = r; opcode = op; rt = t; rd = d; mem_ready = mr;
        e.nm   = nm;
        e.st   = r ? 4'd0 : st;
        e.ctl  = model(r, st, op, t, d, mr);
        e.cnt  = cnt;
        e.terr = terr;
        e.full = !r;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the DUT against the oldest expectation mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.nm, ".state"}, 32'(state), 32'(e.st));
            check({e.nm, ".ctl"},
                  32'({pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
                       mem_size, ir_write, reg_write, mem_to_reg, reg_dst, alu_src_a,
                       alu_src_b, alu_op, pc_source, illegal}),
                  32'(e.ctl));
            if (e.full) begin
                check({e.nm, ".count"}, instr_count, e.cnt);
                check({e.nm, ".terr"}, 32'(timeout_err), 32'(e.terr));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1'b1; opcode = '0; rt = '0; rd = '0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step("reset",      1, 6'h00, 0, 0, 1, 0, 0, 0);

        // R-type to rd=5, zero-wait memory: 0,1,6,7,0
        step("r5_fetch",   0, 6'h00, 0, 5, 1, 0, 0, 0);
        step("r5_dec",     0, 6'h00, 0, 5, 1, 1, 0, 0);
        step("r5_exec",    0, 6'h00, 0, 5, 1, 6, 0, 0);
        step("r5_wb",      0, 6'h00, 0, 5, 1, 7, 0, 0);
        // R-type to rd=0: write suppressed, still retires
        step("r0_fetch",   0, 6'h00, 0, 0, 1, 0, 1, 0);
        step("r0_dec",     0, 6'h00, 0, 0, 1, 1, 1, 0);
        step("r0_exec",    0, 6'h00, 0, 0, 1, 6, 1, 0);
        step("r0_wb",      0, 6'h00, 0, 0, 1, 7, 1, 0);
        // lh rt=3 with two memory wait cycles
        step("lh_fetch",   0, 6'h21, 3, 0, 1, 0, 2, 0);
        step("lh_dec",     0, 6'h21, 3, 0, 1, 1, 2, 0);
        step("lh_addr",    0, 6'h21, 3, 0, 1, 2, 2, 0);
        step("lh_wait1",   0, 6'h21, 3, 0, 0, 3, 2, 0);
        step("lh_wait2",   0, 6'h21, 3, 0, 0, 3, 2, 0);
        step("lh_read",    0, 6'h21, 3, 0, 1, 3, 2, 0);
        step("lh_wb",      0, 6'h21, 3, 0, 1, 4, 2, 0);
        // sb: byte store
        step("sb_fetch",   0, 6'h28, 0, 0, 1, 0, 3, 0);
        step("sb_dec",     0, 6'h28, 0, 0, 1, 1, 3, 0);
        step("sb_addr",    0, 6'h28, 0, 0, 1, 2, 3, 0);
        step("sb_write",   0, 6'h28, 0, 0, 1, 5, 3, 0);
        // beq, j
        step("beq_fetch",  0, 6'h04, 0, 0, 1, 0, 4, 0);
        step("beq_dec",    0, 6'h04, 0, 0, 1, 1, 4, 0);
        step("beq_br",     0, 6'h04, 0, 0, 1, 8, 4, 0);
        step("j_fetch",    0, 6'h02, 0, 0, 1, 0, 5, 0);
        step("j_dec",      0, 6'h02, 0, 0, 1, 1, 5, 0);
        step("j_jump",     0, 6'h02, 0, 0, 1, 9, 5, 0);
        // addi rt=7
        step("addi_fetch", 0, 6'h08, 7, 0, 1, 0, 6, 0);
        step("addi_dec",   0, 6'h08, 7, 0, 1, 1, 6, 0);
        step("addi_exec",  0, 6'h08, 7, 0, 1, 10, 6, 0);
        step("addi_wb",    0, 6'h08, 7, 0, 1, 11, 6, 0);
        // lw to rt=0: write-back visited, write suppressed
        step("lw0_fetch",  0, 6'h23, 0, 0, 1, 0, 7, 0);
        step("lw0_dec",    0, 6'h23, 0, 0, 1, 1, 7, 0);
        step("lw0_addr",   0, 6'h23, 0, 0, 1, 2, 7, 0);
        step("lw0_read",   0, 6'h23, 0, 0, 1, 3, 7, 0);
        step("lw0_wb",     0, 6'h23, 0, 0, 1, 4, 7, 0);
        // illegal opcode: pulse in DECODE, back to FETCH, no retire
        step("ill_fetch",  0, 6'h3F, 0, 0, 1, 0, 8, 0);
        step("ill_dec",    0, 6'h3F, 0, 0, 1, 1, 8, 0);
        // bne: branch when enabled, illegal otherwise
        step("bne_fetch",  0, 6'h05, 0, 0, 1, 0, 8, 0);
        step("bne_dec",    0, 6'h05, 0, 0, 1, 1, 8, 0);
        if (BNE_INC == 1) step("bne_br", 0, 6'h05, 0, 0, 1, 8, 8, 0);
        // sw stalled 14 cycles, ready on the 15th: normal completion wins
        step("swl_fetch",  0, 6'h2B, 0, 0, 1, 0, 8 + BNE_INC, 0);
        step("swl_dec",    0, 6'h2B, 0, 0, 1, 1, 8 + BNE_INC, 0);
        step("swl_addr",   0, 6'h2B, 0, 0, 1, 2, 8 + BNE_INC, 0);
        for (int i = 0; i < 14; i++)
            step("swl_wait", 0, 6'h2B, 0, 0, 0, 5, 8 + BNE_INC, 0);
        step("swl_ready",  0, 6'h2B, 0, 0, 1, 5, 8 + BNE_INC, 0);
        // sw interrupted by reset in MEM_WRITE
        step("swr_fetch",  0, 6'h2B, 0, 0, 1, 0, 9 + BNE_INC, 0);
        step("swr_dec",    0, 6'h2B, 0, 0, 1, 1, 9 + BNE_INC, 0);
        step("swr_addr",   0, 6'h2B, 0, 0, 1, 2, 9 + BNE_INC, 0);
        step("swr_wait",   0, 6'h2B, 0, 0, 0, 5, 9 + BNE_INC, 0);
        step("swr_rst",    1, 6'h2B, 0, 0, 0, 5, 0, 0);
        // FETCH stalled 15 cycles -> ERR, sticky until reset
        for (int i = 0; i < 15; i++)
            step("wd_wait",  0, 6'h00, 0, 0, 0, 0, 0, 0);
        step("wd_err",     0, 6'h00, 0, 0, 1, 15, 0, 1);
        step("wd_hold",    0, 6'h00, 0, 0, 0, 15, 0, 1);
        step("wd_rst",     1, 6'h00, 0, 0, 1, 15, 0, 1);
        step("post_fetch", 0, 6'h00, 0, 0, 1, 0, 0, 0);
        step("post_dec",   0, 6'h00, 0, 0, 1, 1, 0, 0);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d pending required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
